// File: rtl/control_unit.sv
// control_unit -- main decoder for the single-cycle RV32I core.
// Turns opcode/funct3/funct7 into register-file, memory, branch/jump and
// ALU control, flags unsupported encodings, and keeps a sticky record of
// any illegal instruction seen since reset.
// Build option: define CU_OUTPUT_REG_EN to register every decode output
// (control, ALUOp and illegal) for one cycle of latency.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       Branch,
    output logic       Jal,
    output logic       Jalr,
    output logic [3:0] ALUOp,
    output logic       illegal,
    output logic       illegal_seen
);

    // Major opcodes understood by this core.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct7 values that distinguish base and alternate ALU operations.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes shared with the datapath.
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    // Maps funct3 onto an ALU operation for R-type and I-ALU instructions.
    // useAlt picks SUB over ADD and SRA over SRL; the caller decides when
    // the alternate form is allowed (ADDI never sets it).
    function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3, input logic useAlt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = useAlt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = useAlt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Maps a branch funct3 onto the comparison the ALU must perform.
    // Equality tests subtract, signed tests use SLT, unsigned tests SLTU.
    function automatic logic [3:0] aluFromBranch(input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_SUB;
        case (f3)
            3'b000, 3'b001: op = ALU_SUB;
            3'b100, 3'b101: op = ALU_SLT;
            3'b110, 3'b111: op = ALU_SLTU;
            default:        op = ALU_SUB;
        endcase
        return op;
    endfunction

    // Raw decode before illegal masking.
    logic       w_decRegWrite;
    logic       w_decMemRead;
    logic       w_decMemWrite;
    logic       w_decMemtoReg;
    logic       w_decAluSrc;
    logic       w_decBranch;
    logic       w_decJal;
    logic       w_decJalr;
    logic [3:0] w_decAluOp;
    logic       w_decIllegal;

    // Decode after illegal masking; this is what leaves the block.
    logic       w_regWrite;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_memtoReg;
    logic       w_aluSrc;
    logic       w_branch;
    logic       w_jal;
    logic       w_jalr;
    logic [3:0] w_aluOp;
    logic       w_illegal;

    // Illegal flag as seen at the output pins, in either build.
    logic       w_illegalOut;

    // Sticky illegal-instruction record.
    logic       r_illegalSeen;

    // Per-opcode decode: set the class controls and work out whether the
    // funct3/funct7 combination is one this core actually supports.
    always_comb begin
        w_decRegWrite = 1'b0;
        w_decMemRead  = 1'b0;
        w_decMemWrite = 1'b0;
        w_decMemtoReg = 1'b0;
        w_decAluSrc   = 1'b0;
        w_decBranch   = 1'b0;
        w_decJal      = 1'b0;
        w_decJalr     = 1'b0;
        w_decAluOp    = ALU_ADD;
        w_decIllegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                w_decRegWrite = 1'b1;
                w_decAluOp    = aluFromFunct3(funct3, funct7 == F7_ALT);
                w_decIllegal  = !((funct7 == F7_BASE) ||
                                  ((funct7 == F7_ALT) &&
                                   ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_IALU: begin
                w_decRegWrite = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = aluFromFunct3(funct3,
                                              (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b001) begin
                    w_decIllegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    w_decIllegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
                end else begin
                    w_decIllegal = 1'b0;
                end
            end
            OP_LUI: begin
                w_decRegWrite = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = ALU_PASS_B;
            end
            OP_AUIPC: begin
                w_decRegWrite = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = ALU_ADD;
            end
            OP_STORE: begin
                w_decMemWrite = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = ALU_ADD;
                w_decIllegal  = (funct3 > 3'b010);
            end
            OP_LOAD: begin
                w_decMemRead  = 1'b1;
                w_decRegWrite = 1'b1;
                w_decMemtoReg = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = ALU_ADD;
                w_decIllegal  = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                (funct3 == 3'b111);
            end
            OP_BRANCH: begin
                w_decBranch  = 1'b1;
                w_decAluOp   = aluFromBranch(funct3);
                w_decIllegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                w_decRegWrite = 1'b1;
                w_decJal      = 1'b1;
                w_decAluOp    = ALU_ADD;
            end
            OP_JALR: begin
                w_decRegWrite = 1'b1;
                w_decJalr     = 1'b1;
                w_decAluSrc   = 1'b1;
                w_decAluOp    = ALU_ADD;
                w_decIllegal  = (funct3 != 3'b000);
            end
            default: begin
                w_decIllegal = 1'b1;
            end
        endcase
    end

    // An illegal encoding must not disturb machine state, so every control
    // line and the ALU code are forced to zero whenever illegal is raised.
    always_comb begin
        w_illegal  = w_decIllegal;
        w_regWrite = w_decRegWrite & ~w_decIllegal;
        w_memRead  = w_decMemRead  & ~w_decIllegal;
        w_memWrite = w_decMemWrite & ~w_decIllegal;
        w_memtoReg = w_decMemtoReg & ~w_decIllegal;
        w_aluSrc   = w_decAluSrc   & ~w_decIllegal;
        w_branch   = w_decBranch   & ~w_decIllegal;
        w_jal      = w_decJal      & ~w_decIllegal;
        w_jalr     = w_decJalr     & ~w_decIllegal;
        w_aluOp    = w_decIllegal ? 4'b0000 : w_decAluOp;
    end

`ifdef CU_OUTPUT_REG_EN
    logic       r_regWrite;
    logic       r_memRead;
    logic       r_memWrite;
    logic       r_memtoReg;
    logic       r_aluSrc;
    logic       r_branch;
    logic       r_jal;
    logic       r_jalr;
    logic [3:0] r_aluOp;
    logic       r_illegal;

    // Output pipeline register: one cycle of latency, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memtoReg <= 1'b0;
            r_aluSrc   <= 1'b0;
            r_branch   <= 1'b0;
            r_jal      <= 1'b0;
            r_jalr     <= 1'b0;
            r_aluOp    <= 4'b0000;
            r_illegal  <= 1'b0;
        end else begin
            r_regWrite <= w_regWrite;
            r_memRead  <= w_memRead;
            r_memWrite <= w_memWrite;
            r_memtoReg <= w_memtoReg;
            r_aluSrc   <= w_aluSrc;
            r_branch   <= w_branch;
            r_jal      <= w_jal;
            r_jalr     <= w_jalr;
            r_aluOp    <= w_aluOp;
            r_illegal  <= w_illegal;
        end
    end

    assign RegWrite     = r_regWrite;
    assign MemRead      = r_memRead;
    assign MemWrite     = r_memWrite;
    assign MemtoReg     = r_memtoReg;
    assign ALUSrc       = r_aluSrc;
    assign Branch       = r_branch;
    assign Jal          = r_jal;
    assign Jalr         = r_jalr;
    assign ALUOp        = r_aluOp;
    assign w_illegalOut = r_illegal;
`else
    assign RegWrite     = w_regWrite;
    assign MemRead      = w_memRead;
    assign MemWrite     = w_memWrite;
    assign MemtoReg     = w_memtoReg;
    assign ALUSrc       = w_aluSrc;
    assign Branch       = w_branch;
    assign Jal          = w_jal;
    assign Jalr         = w_jalr;
    assign ALUOp        = w_aluOp;
    assign w_illegalOut = w_illegal;
`endif

    assign illegal = w_illegalOut;

    // Sticky flag: once an illegal encoding reaches the output it stays
    // recorded until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegalSeen <= 1'b0;
        end else if (w_illegalOut) begin
            r_illegalSeen <= 1'b1;
        end
    end

    assign illegal_seen = r_illegalSeen;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- directed self-checking bench for control_unit
// (default build, combinational decode).
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       Branch;
    logic       Jal;
    logic       Jalr;
    logic [3:0] ALUOp;
    logic       illegal;
    logic       illegal_seen;

    int compared;
    int mismatched;

    control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .ALUSrc       (ALUSrc),
        .Branch       (Branch),
        .Jal          (Jal),
        .Jalr         (Jalr),
        .ALUOp        (ALUOp),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    // 10-unit core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one encoding just after a falling edge, settle, then sample
    // well away from the rising edge.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7);
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        #1;
    endtask

    // Vector layout: RegWrite MemRead MemWrite MemtoReg ALUSrc Branch Jal
    // Jalr ALUOp[3:0] illegal.
    task automatic checkOutput(input string tag, input logic [12:0] expVec);
        logic [12:0] obs;
        obs = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jal,
               Jalr, ALUOp, illegal};
        compared++;
        assert (obs === expVec) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expVec);
        end
    endtask

    task automatic checkSeen(input string tag, input logic expSeen);
        compared++;
        assert (illegal_seen === expSeen) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed illegal_seen=%b expected=%b",
                   tag, illegal_seen, expSeen);
        end
    endtask

    localparam logic [12:0] V_ILLEGAL = 13'b0_0_0_0_0_0_0_0_0000_1;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n  = 1'b0;
        opcode = 7'b0110111;
        funct3 = 3'b000;
        funct7 = 7'b0000000;

        #3;
        checkSeen("reset_seen", 1'b0);
        checkOutput("lui_in_reset", 13'b1_0_0_0_1_0_0_0_1010_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Legal encodings.
        applyStimulus(7'b0110011, 3'b000, 7'b0100000);
        checkOutput("r_sub",   13'b1_0_0_0_0_0_0_0_0001_0);
        applyStimulus(7'b0110011, 3'b000, 7'b0000000);
        checkOutput("r_add",   13'b1_0_0_0_0_0_0_0_0000_0);
        applyStimulus(7'b0110011, 3'b011, 7'b0000000);
        checkOutput("r_sltu",  13'b1_0_0_0_0_0_0_0_0100_0);
        applyStimulus(7'b0110011, 3'b101, 7'b0100000);
        checkOutput("r_sra",   13'b1_0_0_0_0_0_0_0_0111_0);
        applyStimulus(7'b0110011, 3'b111, 7'b0000000);
        checkOutput("r_and",   13'b1_0_0_0_0_0_0_0_1001_0);
        applyStimulus(7'b0010011, 3'b000, 7'b0100000);
        checkOutput("addi_imm_alt", 13'b1_0_0_0_1_0_0_0_0000_0);
        applyStimulus(7'b0010011, 3'b101, 7'b0100000);
        checkOutput("srai",    13'b1_0_0_0_1_0_0_0_0111_0);
        applyStimulus(7'b0010011, 3'b101, 7'b0000000);
        checkOutput("srli",    13'b1_0_0_0_1_0_0_0_0110_0);
        applyStimulus(7'b0010011, 3'b110, 7'b1111111);
        checkOutput("ori",     13'b1_0_0_0_1_0_0_0_1000_0);
        applyStimulus(7'b0110111, 3'b000, 7'b0000000);
        checkOutput("lui",     13'b1_0_0_0_1_0_0_0_1010_0);
        applyStimulus(7'b0010111, 3'b000, 7'b0000000);
        checkOutput("auipc",   13'b1_0_0_0_1_0_0_0_0000_0);
        applyStimulus(7'b0000011, 3'b010, 7'b0000000);
        checkOutput("lw",      13'b1_1_0_1_1_0_0_0_0000_0);
        applyStimulus(7'b0000011, 3'b101, 7'b0000000);
        checkOutput("lhu",     13'b1_1_0_1_1_0_0_0_0000_0);
        applyStimulus(7'b0100011, 3'b010, 7'b0000000);
        checkOutput("sw",      13'b0_0_1_0_1_0_0_0_0000_0);
        applyStimulus(7'b1100011, 3'b100, 7'b0000000);
        checkOutput("blt",     13'b0_0_0_0_0_1_0_0_0011_0);
        applyStimulus(7'b1100011, 3'b000, 7'b0000000);
        checkOutput("beq",     13'b0_0_0_0_0_1_0_0_0001_0);
        applyStimulus(7'b1100011, 3'b111, 7'b0000000);
        checkOutput("bgeu",    13'b0_0_0_0_0_1_0_0_0100_0);
        applyStimulus(7'b1101111, 3'b000, 7'b0000000);
        checkOutput("jal",     13'b1_0_0_0_0_0_1_0_0000_0);
        applyStimulus(7'b1100111, 3'b000, 7'b0000000);
        checkOutput("jalr",    13'b1_0_0_0_1_0_0_1_0000_0);
        checkSeen("seen_after_legal", 1'b0);

        // Unknown opcode: flag rises combinationally, sticky bit on the edge.
        applyStimulus(7'b0000000, 3'b000, 7'b0000000);
        checkOutput("op_zero", V_ILLEGAL);
        checkSeen("seen_before_edge", 1'b0);
        @(posedge clk);
        #1;
        checkSeen("seen_after_edge", 1'b1);
        applyStimulus(7'b0110111, 3'b000, 7'b0000000);
        @(posedge clk);
        #1;
        checkSeen("seen_sticky", 1'b1);

        // Asynchronous reset pulse clears the sticky bit only.
        rst_n = 1'b0;
        #1;
        checkSeen("seen_async_clear", 1'b0);
        checkOutput("lui_during_reset", 13'b1_0_0_0_1_0_0_0_1010_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsupported funct combinations within known opcodes.
        applyStimulus(7'b0110011, 3'b001, 7'b0100000);
        checkOutput("r_alt_bad_f3", V_ILLEGAL);
        applyStimulus(7'b0110011, 3'b000, 7'b0000001);
        checkOutput("r_bad_f7", V_ILLEGAL);
        applyStimulus(7'b0010011, 3'b001, 7'b0000001);
        checkOutput("slli_bad_f7", V_ILLEGAL);
        applyStimulus(7'b0010011, 3'b101, 7'b0100001);
        checkOutput("sri_bad_f7", V_ILLEGAL);
        applyStimulus(7'b0000011, 3'b011, 7'b0000000);
        checkOutput("load_f3_011", V_ILLEGAL);
        applyStimulus(7'b0100011, 3'b011, 7'b0000000);
        checkOutput("store_f3_011", V_ILLEGAL);
        applyStimulus(7'b1100011, 3'b010, 7'b0000000);
        checkOutput("branch_f3_010", V_ILLEGAL);
        applyStimulus(7'b1100111, 3'b001, 7'b0000000);
        checkOutput("jalr_f3_001", V_ILLEGAL);
        @(posedge clk);
        #1;
        checkSeen("seen_reset_then_set", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
